mem_stage_access: RTL and testbench

- MEM-stage consumer of the EXE/MEM pipeline register outputs (mem_* signals) in the 16-bit RISC pipeline.
- Issues loads and stores to data memory over a variable-latency req/ack handshake and stalls upstream while an access is outstanding.
- Selects the writeback value and registers the MEM/WB-side results (wb_*) for the writeback stage.

---
 rtl/mem_stage_access.sv | 163 ++++++++++++++++
 tb/tb_mem_stage_access.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM stage that issues data-memory loads/stores over req/ack and registers writeback results.
// Ports: clock/reset (async active-high); mem_* EXE/MEM inputs; dmem_* memory handshake;
// stall to upstream; wb_* registered MEM/WB outputs; mem_err sticky timeout flag.
// Optional: define MEM_TIMEOUT_EN to abort accesses after TIMEOUT BUSY cycles without ack.
module mem_stage_access #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] mem_alu_out,
  input  logic [15:0] mem_mem_write_data,
  input  logic [2:0]  mem_fwd_reg,
  input  logic [7:0]  mem_lb_const,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_memtoreg,
  input  logic        mem_regwrite,
  input  logic [3:0]  mem_opcode,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        wb_regwrite,
  output logic [2:0]  wb_fwd_reg,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_opcode,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [7:0] lb_q, lb_d;
  logic [3:0] opc_q, opc_d, wb_opc_q, wb_opc_d;
  logic [2:0] fwd_q, fwd_d, wb_fwd_q, wb_fwd_d;
  logic [1:0] sel_q, sel_d;
  logic rw_q, rw_d, we_q, we_d, wb_rw_q, wb_rw_d;
  logic op;
  assign op = mem_mem_read | mem_mem_write;
  function automatic logic [15:0] wb_mux(input logic [1:0] sel, input logic [15:0] alu, input logic [15:0] rd,
                                         input logic [7:0] lb);
    return sel == 2'd0 ? alu : sel == 2'd1 ? rd : sel == 2'd2 ? {8'h00, lb} : {lb, alu[7:0]};
  endfunction
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    fwd_d = fwd_q;
    lb_d = lb_q;
    sel_d = sel_q;
    rw_d = rw_q;
    opc_d = opc_q;
    we_d = we_q;
    wb_rw_d = wb_rw_q;
    wb_fwd_d = wb_fwd_q;
    wb_data_d = wb_data_q;
    wb_opc_d = wb_opc_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (op) begin
        addr_d = mem_alu_out;
        wdata_d = mem_mem_write_data;
        fwd_d = mem_fwd_reg;
        lb_d = mem_lb_const;
        sel_d = mem_memtoreg;
        rw_d = mem_regwrite;
        opc_d = mem_opcode;
        we_d = mem_mem_write;
        wb_rw_d = 1'b0;
        state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
        cnt_d = 8'd0;
`endif
      end else begin
        wb_rw_d = mem_regwrite;
        wb_fwd_d = mem_fwd_reg;
        wb_opc_d = mem_opcode;
        wb_data_d = wb_mux(mem_memtoreg, mem_alu_out, dmem_rdata, mem_lb_const);
      end
      BUSY: if (dmem_ack) begin
        wb_rw_d = rw_q;
        wb_fwd_d = fwd_q;
        wb_opc_d = opc_q;
        wb_data_d = wb_mux(sel_q, addr_q, dmem_rdata, lb_q);
        state_d = DONE;
      end else begin
        wb_rw_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
        if (cnt_q == 8'(TIMEOUT - 1)) begin
          wb_data_d = 16'h0000;
          err_d = 1'b1;
          state_d = DONE;
        end else cnt_d = cnt_q + 8'd1;
`endif
      end
      DONE: begin
        wb_rw_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      fwd_q <= '0;
      lb_q <= '0;
      sel_q <= '0;
      rw_q <= 1'b0;
      opc_q <= '0;
      we_q <= 1'b0;
      wb_rw_q <= 1'b0;
      wb_fwd_q <= '0;
      wb_data_q <= '0;
      wb_opc_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      fwd_q <= fwd_d;
      lb_q <= lb_d;
      sel_q <= sel_d;
      rw_q <= rw_d;
      opc_q <= opc_d;
      we_q <= we_d;
      wb_rw_q <= wb_rw_d;
      wb_fwd_q <= wb_fwd_d;
      wb_data_q <= wb_data_d;
      wb_opc_q <= wb_opc_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  assign dmem_req = state_q == BUSY;
  assign dmem_we = we_q;
  assign dmem_addr = addr_q;
  assign dmem_wdata = wdata_q;
  // Reset gates the combinational IDLE&op term so every output reads 0 while reset is held.
  assign stall = !reset && ((state_q == IDLE && op) || state_q == BUSY);
  assign wb_regwrite = wb_rw_q;
  assign wb_fwd_reg = wb_fwd_q;
  assign wb_data = wb_data_q;
  assign wb_opcode = wb_opc_q;
endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: table-driven scoreboard bench for mem_stage_access.
module tb_mem_stage_access;
  logic clock = 1'b0, reset = 1'b1;
  logic [15:0] mem_alu_out = '0, mem_mem_write_data = '0, dmem_rdata = '0;
  logic [2:0] mem_fwd_reg = '0;
  logic [7:0] mem_lb_const = '0;
  logic mem_mem_read = 1'b0, mem_mem_write = 1'b0, mem_regwrite = 1'b0, dmem_ack = 1'b0;
  logic [1:0] mem_memtoreg = '0;
  logic [3:0] mem_opcode = '0;
  logic dmem_req, dmem_we, stall, wb_regwrite, mem_err;
  logic [15:0] dmem_addr, dmem_wdata, wb_data;
  logic [2:0] wb_fwd_reg;
  logic [3:0] wb_opcode;
  int n_cmp = 0, n_bad = 0;
  always #5 clock = ~clock;
  mem_stage_access #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .mem_alu_out(mem_alu_out), .mem_mem_write_data(mem_mem_write_data),
    .mem_fwd_reg(mem_fwd_reg), .mem_lb_const(mem_lb_const), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
    .mem_opcode(mem_opcode), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
    .wb_regwrite(wb_regwrite), .wb_fwd_reg(wb_fwd_reg), .wb_data(wb_data), .wb_opcode(wb_opcode),
    .mem_err(mem_err));
  typedef struct {
    logic rd, wr;
    logic [15:0] alu, wdata;
    logic [2:0] fwd;
    logic [7:0] lb;
    logic [1:0] sel;
    logic rw;
    logic [3:0] opc;
    logic [15:0] rdata;
    int lat;
    logic [15:0] e_data;
    logic e_rw;
  } vec_t;
  typedef struct {
    logic [15:0] data;
    logic rw;
    logic [2:0] fwd;
    logic [3:0] opc;
  } exp_t;
  exp_t sb[$];
  vec_t vecs[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) chk({tag, " sb_empty"}, 1, 0);
    else begin
      e = sb.pop_front();
      chk({tag, " wb_data"}, wb_data, e.data);
      chk({tag, " wb_regwrite"}, wb_regwrite, e.rw);
      chk({tag, " wb_fwd_reg"}, wb_fwd_reg, e.fwd);
      chk({tag, " wb_opcode"}, wb_opcode, e.opc);
    end
  endtask
  task automatic set_in(input vec_t v);
    mem_mem_read = v.rd;
    mem_mem_write = v.wr;
    mem_alu_out = v.alu;
    mem_mem_write_data = v.wdata;
    mem_fwd_reg = v.fwd;
    mem_lb_const = v.lb;
    mem_memtoreg = v.sel;
    mem_regwrite = v.rw;
    mem_opcode = v.opc;
  endtask
  task automatic run_vec(input string tag, input vec_t v);
    sb.push_back('{v.e_data, v.e_rw, v.fwd, v.opc});
    set_in(v);
    #1;
    if (!(v.rd | v.wr)) begin
      chk({tag, " stall"}, stall, 0);
      chk({tag, " req"}, dmem_req, 0);
      @(posedge clock);
      @(negedge clock);
      pop_cmp(tag);
    end else begin
      chk({tag, " stall_idle"}, stall, 1);
      chk({tag, " req_idle"}, dmem_req, 0);
      @(posedge clock);
      for (int k = 1; k <= v.lat; k++) begin
        @(negedge clock);
        dmem_ack = k == v.lat;
        dmem_rdata = k == v.lat ? v.rdata : 16'h0BAD;
        #1;
        chk({tag, " req_busy"}, dmem_req, 1);
        chk({tag, " stall_busy"}, stall, 1);
        chk({tag, " we"}, dmem_we, v.wr);
        chk({tag, " addr"}, dmem_addr, v.alu);
        if (v.wr) chk({tag, " wdata"}, dmem_wdata, v.wdata);
        chk({tag, " bubble"}, wb_regwrite, 0);
        @(posedge clock);
      end
      @(negedge clock);
      dmem_ack = 1'b0;
      #1;
      chk({tag, " stall_done"}, stall, 0);
      chk({tag, " req_done"}, dmem_req, 0);
      pop_cmp(tag);
      @(posedge clock);
      @(negedge clock);
      chk({tag, " post_rw"}, wb_regwrite, 0);
    end
    mem_mem_read = 1'b0;
    mem_mem_write = 1'b0;
  endtask
  initial begin
    vecs[0] = '{0, 0, 16'h1234, 16'h0000, 3'd3, 8'h00, 2'd0, 1, 4'h1, 16'h0000, 0, 16'h1234, 1};
    vecs[1] = '{1, 0, 16'h0040, 16'h0000, 3'd5, 8'h00, 2'd1, 1, 4'h8, 16'hBEEF, 3, 16'hBEEF, 1};
    vecs[2] = '{0, 1, 16'h0010, 16'hA5A5, 3'd2, 8'h00, 2'd0, 0, 4'h9, 16'h0000, 1, 16'h0010, 0};
    vecs[3] = '{0, 0, 16'h12C3, 16'h0000, 3'd1, 8'h7E, 2'd2, 1, 4'h2, 16'h0000, 0, 16'h007E, 1};
    vecs[4] = '{0, 0, 16'h12C3, 16'h0000, 3'd6, 8'h7E, 2'd3, 1, 4'h3, 16'h0000, 0, 16'h7EC3, 1};
    vecs[5] = '{1, 1, 16'h0020, 16'h5A5A, 3'd4, 8'h00, 2'd1, 1, 4'hA, 16'h1111, 2, 16'h1111, 1};
    vecs[6] = '{1, 0, 16'h00F0, 16'h0000, 3'd7, 8'h3C, 2'd3, 1, 4'hB, 16'hDEAD, 1, 16'h3CF0, 1};
    vecs[7] = '{1, 0, 16'h0100, 16'h0000, 3'd1, 8'h99, 2'd2, 1, 4'hC, 16'hCAFE, 4, 16'h0099, 1};
    #3;
    chk("rst req", dmem_req, 0);
    chk("rst we", dmem_we, 0);
    chk("rst addr", dmem_addr, 0);
    chk("rst wdata", dmem_wdata, 0);
    chk("rst stall", stall, 0);
    chk("rst wb_rw", wb_regwrite, 0);
    chk("rst wb_fwd", wb_fwd_reg, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst wb_opc", wb_opcode, 0);
    chk("rst err", mem_err, 0);
    @(negedge clock);
    reset = 1'b0;
    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);
    mem_regwrite = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 16'hFFFF;
    #1;
    chk("stray_ack stall", stall, 0);
    @(posedge clock);
    @(negedge clock);
    dmem_ack = 1'b0;
    #1;
    chk("stray_ack req", dmem_req, 0);
    chk("stray_ack wb_rw", wb_regwrite, 0);
    set_in(vecs[1]);
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst req", dmem_req, 0);
    chk("midrst stall", stall, 0);
    chk("midrst wb_rw", wb_regwrite, 0);
    chk("midrst wb_data", wb_data, 0);
    chk("midrst wb_fwd", wb_fwd_reg, 0);
    chk("midrst wb_opc", wb_opcode, 0);
    @(negedge clock);
    reset = 1'b0;
    mem_mem_read = 1'b0;
    mem_regwrite = 1'b0;
    @(negedge clock);
    dmem_ack = 1'b1;
    dmem_rdata = 16'h7777;
    @(negedge clock);
    dmem_ack = 1'b0;
    #1;
    chk("midrst late_ack req", dmem_req, 0);
    chk("midrst late_ack wb_rw", wb_regwrite, 0);
    @(negedge clock);
    run_vec("after_rst", vecs[6]);
`ifdef MEM_TIMEOUT_EN
    set_in('{1, 0, 16'h0050, 16'h0000, 3'd2, 8'h00, 2'd1, 1, 4'h8, 16'h0000, 0, 16'h0000, 0});
    @(posedge clock);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      #1;
      chk("to req_busy", dmem_req, 1);
      chk("to err_busy", mem_err, 0);
      @(posedge clock);
    end
    @(negedge clock);
    #1;
    chk("to req_done", dmem_req, 0);
    chk("to stall_done", stall, 0);
    chk("to err", mem_err, 1);
    chk("to wb_rw", wb_regwrite, 0);
    chk("to wb_data", wb_data, 0);
    @(posedge clock);
    @(negedge clock);
    mem_mem_read = 1'b0;
    run_vec("to_good", vecs[1]);
    chk("to err_sticky", mem_err, 1);
`else
    chk("no_to err", mem_err, 0);
`endif
    chk("sb drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
